// File: rtl/pwm_fade_pkg.sv
// ============================================================================
// Module      : pwm_fade_pkg
// Description : Shared types for the PWM fade envelope sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_fade_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_HOLD_HI = 3'd2,
        S_FALL    = 3'd3,
        S_HOLD_LO = 3'd4
    } fade_state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_generator.sv
// ============================================================================
// Module      : pulse_generator
// Description : Emits a one-cycle pulse every `ticks` enabled clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_generator #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] ticks,
    output logic         out
);

    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt >= (ticks - c_one));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (ena) begin
            r_cnt <= w_wrap ? '0 : (r_cnt + c_one);
        end
    end

    // Combinational pulse so a freeze never leaves a stale step pending.
    assign out = ena & ~rst & w_wrap;

endmodule

`default_nettype wire

// File: rtl/pwm_fade_sequencer.sv
// ============================================================================
// Module      : pwm_fade_sequencer
// Description : Drives pwm duty through rise / hold-high / fall / hold-low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_fade_sequencer
    import pwm_fade_pkg::*;
#(
    parameter int N = 4,
    parameter int T = 16,
    parameter int H = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         stop,
    input  logic         continuous,
    input  logic [T-1:0] ramp_ticks,
    input  logic [H-1:0] hold_steps,
    input  logic [N-1:0] duty_max,
    output logic [N-1:0] duty,
    output logic         busy,
    output logic [2:0]   state,
    output logic         done
);

    localparam logic [N-1:0] c_duty_one = {{(N-1){1'b0}}, 1'b1};
    localparam logic [H-1:0] c_hold_one = {{(H-1){1'b0}}, 1'b1};

    fade_state_t  r_state, w_state_nxt;
    logic [N-1:0] r_duty, w_duty_nxt, r_duty_max_l;
    logic [H-1:0] r_hold_cnt, w_hold_cnt_nxt, r_hold_steps_l;
    logic [T-1:0] r_ramp_ticks_l;
    logic         r_done, w_done_nxt;
    logic         w_latch, w_fade_step, w_busy, w_pg_rst;

    assign w_busy   = (r_state != S_IDLE);
    assign w_pg_rst = rst | ~w_busy;

    pulse_generator #(.N(T)) u_prescaler (
        .clk   (clk),
        .rst   (w_pg_rst),
        .ena   (ena),
        .ticks (r_ramp_ticks_l),
        .out   (w_fade_step)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_hold_cnt_nxt = r_hold_cnt;
        w_done_nxt     = r_done;
        w_latch        = 1'b0;
        if (ena) begin
            w_done_nxt = 1'b0;
            if (stop) begin
                w_state_nxt = S_IDLE;
                w_duty_nxt  = '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_duty_nxt = '0;
                        if (start) begin
                            w_latch     = 1'b1;
                            w_state_nxt = S_RISE;
                        end
                    end
                    S_RISE: if (w_fade_step) begin
                        if (r_duty >= r_duty_max_l) begin
                            w_state_nxt    = S_HOLD_HI;
                            w_hold_cnt_nxt = '0;
                        end else begin
                            w_duty_nxt = r_duty + c_duty_one;
                        end
                    end
                    S_HOLD_HI: if (w_fade_step) begin
                        if (r_hold_cnt == r_hold_steps_l) w_state_nxt = S_FALL;
                        else w_hold_cnt_nxt = r_hold_cnt + c_hold_one;
                    end
                    S_FALL: if (w_fade_step) begin
                        if (r_duty == '0) begin
                            w_state_nxt    = S_HOLD_LO;
                            w_hold_cnt_nxt = '0;
                        end else begin
                            w_duty_nxt = r_duty - c_duty_one;
                        end
                    end
                    S_HOLD_LO: if (w_fade_step) begin
                        if (r_hold_cnt == r_hold_steps_l) begin
                            // Repeat keeps the latched config; finishing reports done.
                            if (continuous) begin
                                w_state_nxt = S_RISE;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_hold_cnt_nxt = r_hold_cnt + c_hold_one;
                        end
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                        w_duty_nxt  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_duty         <= '0;
            r_hold_cnt     <= '0;
            r_done         <= 1'b0;
            r_duty_max_l   <= '0;
            r_hold_steps_l <= '0;
            r_ramp_ticks_l <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_done     <= w_done_nxt;
            if (w_latch) begin
                r_duty_max_l   <= duty_max;
                r_hold_steps_l <= hold_steps;
                r_ramp_ticks_l <= ramp_ticks;
            end
        end
    end

    assign duty  = r_duty;
    assign busy  = w_busy;
    assign state = r_state;
    assign done  = r_done;

endmodule

`default_nettype wire
